md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl.sv | 114 +++++++++++
 tb/tb_md_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle multiply/divide unit with HI/LO registers.
// Holds the E stage via stall_E while an md instruction waits on the unit.
module md_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        md_use_E,
  output logic        busy,
  output logic        stall_E,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MulCnt = 4'(MULT_LAT);
  localparam logic [3:0] DivCnt = 4'(DIV_LAT);

  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] pending;
  logic        skipWr;

  logic        isArith;
  logic        sgnDiv;
  logic        negA;
  logic        negB;
  logic [31:0] absA;
  logic [31:0] absB;
  logic [31:0] divisor;
  logic [31:0] qMag;
  logic [31:0] rMag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [63:0] prodS;
  logic [63:0] prodU;
  logic [63:0] result;

  assign isArith = start & ~op[2];
  assign busy    = (state == RUN) | isArith;
  assign stall_E = md_use_E & busy;

  assign prodS = $signed({{32{srcA[31]}}, srcA})
               * $signed({{32{srcB[31]}}, srcB});
  assign prodU = {32'd0, srcA} * {32'd0, srcB};

  // Divide on magnitudes so 0x80000000 / -1 stays well defined.
  assign sgnDiv  = ~op[0];
  assign negA    = sgnDiv & srcA[31];
  assign negB    = sgnDiv & srcB[31];
  assign absA    = negA ? -srcA : srcA;
  assign absB    = negB ? -srcB : srcB;
  assign divisor = (absB == 32'd0) ? 32'd1 : absB;
  assign qMag    = absA / divisor;
  assign rMag    = absA % divisor;
  assign quo     = (negA ^ negB) ? -qMag : qMag;
  assign rem     = negA ? -rMag : rMag;

  always_comb begin
    result = prodU;
    unique case (op[1:0])
      2'b00:   result = prodS;
      2'b01:   result = prodU;
      default: result = {rem, quo};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pending <= 64'd0;
      skipWr  <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (1'b1)
              !op[2]: begin
                pending <= result;
                skipWr  <= op[1] & (srcB == 32'd0);
                cnt     <= op[1] ? DivCnt : MulCnt;
                state   <= RUN;
              end
              op == 3'd4: hi <= srcA;
              op == 3'd5: lo <= srcA;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            if (!skipWr) begin
              hi <= pending[63:32];
              lo <= pending[31:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed vectors for md_ctrl.
// Latencies fixed at MULT_LAT=5, DIV_LAT=10.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] srcA = 32'd0;
  logic [31:0] srcB = 32'd0;
  logic        md_use_E = 1'b0;
  logic        busy;
  logic        stall_E;
  logic [31:0] hi;
  logic [31:0] lo;

  int nChecks = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  md_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .srcA(srcA),
    .srcB(srcB),
    .md_use_E(md_use_E),
    .busy(busy),
    .stall_E(stall_E),
    .hi(hi),
    .lo(lo)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runOp(input logic [2:0]  o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input int          lat,
                       input logic        useE,
                       input logic [31:0] oldHi,
                       input logic [31:0] oldLo,
                       input logic [31:0] eHi,
                       input logic [31:0] eLo);
    start = 1'b1;
    op = o;
    srcA = a;
    srcB = b;
    md_use_E = useE;
    #1;
    chk("busy_issue", busy, 1);
    chk("stall_issue", stall_E, useE);
    tick();
    start = 1'b0;
    for (int i = 0; i < lat; i++) begin
      #1;
      chk("busy_run", busy, 1);
      chk("stall_run", stall_E, useE);
      chk("hi_hold", hi, oldHi);
      chk("lo_hold", lo, oldLo);
      tick();
    end
    #1;
    chk("busy_done", busy, 0);
    chk("stall_done", stall_E, 0);
    chk("hi_commit", hi, eHi);
    chk("lo_commit", lo, eLo);
    md_use_E = 1'b0;
  endtask

  task automatic mtx(input logic [2:0] o, input logic [31:0] a);
    start = 1'b1;
    op = o;
    srcA = a;
    md_use_E = 1'b1;
    #1;
    chk("busy_mt", busy, 0);
    chk("stall_mt", stall_E, 0);
    tick();
    start = 1'b0;
    md_use_E = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_E, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    tick();
    tick();
    #2;
    reset = 1'b1;

    // first edge after release; mfhi waiting in E
    runOp(3'd0, 32'd3, 32'hFFFFFFFE, 5, 1'b1,
          32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    // an add in E is never stalled
    runOp(3'd1, 32'd3, 32'hFFFFFFFE, 5, 1'b0,
          32'hFFFFFFFF, 32'hFFFFFFFA, 32'h2, 32'hFFFFFFFA);
    runOp(3'd2, 32'hFFFFFFF9, 32'd2, 10, 1'b1,
          32'h2, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp(3'd3, 32'd7, 32'd2, 10, 1'b0,
          32'hFFFFFFFF, 32'hFFFFFFFD, 32'h1, 32'h3);
    runOp(3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0,
          32'h1, 32'h3, 32'h0, 32'h80000000);

    mtx(3'd4, 32'h11);
    chk("mthi", hi, 32'h11);
    chk("mthi_lo", lo, 32'h80000000);
    mtx(3'd5, 32'h22);
    chk("mtlo", lo, 32'h22);
    runOp(3'd3, 32'd9, 32'd0, 10, 1'b0,
          32'h11, 32'h22, 32'h11, 32'h22);

    // op 6/7 are no-ops
    mtx(3'd6, 32'hDEAD);
    mtx(3'd7, 32'hBEEF);
    chk("nop_hi", hi, 32'h11);
    chk("nop_lo", lo, 32'h22);

    // a second start mid-divide is dropped
    start = 1'b1;
    op = 3'd2;
    srcA = 32'd100;
    srcB = 32'd7;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    op = 3'd0;
    srcA = 32'd5;
    srcB = 32'd5;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("ign_busy", busy, 1);
    chk("ign_hi", hi, 32'h11);
    tick();
    chk("ign_hi_c", hi, 32'd2);
    chk("ign_lo_c", lo, 32'd14);
    chk("ign_busy_c", busy, 0);
    repeat (6) tick();
    chk("ign_lo_late", lo, 32'd14);
    chk("ign_hi_late", hi, 32'd2);

    // reset aborts a running divide
    start = 1'b1;
    op = 3'd2;
    srcA = 32'd100;
    srcB = 32'd3;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    md_use_E = 1'b1;
    #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_stall", stall_E, 0);
    #2;
    reset = 1'b1;
    md_use_E = 1'b0;
    runOp(3'd0, 32'd6, 32'd7, 5, 1'b0,
          32'h0, 32'h0, 32'h0, 32'd42);
    repeat (8) tick();
    chk("abort_nolate_hi", hi, 0);
    chk("abort_nolate_lo", lo, 32'd42);
    chk("abort_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
